// File: rtl/snake_step_sequencer.sv
// Snake head stepper: shares one external 5-bit adder (carry-in 1) between an X pass and a Y pass
// per movement tick, and owns direction selection, reversal rejection, wall/wrap policy and overrun.
module snake_step_sequencer #(
    parameter logic [4:0] START_X   = 5'd16,
    parameter logic [4:0] START_Y   = 5'd16,
    parameter logic [1:0] START_DIR = 2'b01,
    parameter bit         WRAP      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       restart,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    output logic [4:0] add_a,
    output logic [4:0] add_b,
    input  logic [4:0] add_s,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] cur_dir,
    output logic       busy,
    output logic       done,
    output logic       collide,
    output logic       overrun
);

    // With carry-in fixed at 1, S = A + B + 1 gives +1, -1 and pass-through.
    localparam logic [4:0] OP_INC  = 5'b00000;
    localparam logic [4:0] OP_DEC  = 5'b11110;
    localparam logic [4:0] OP_HOLD = 5'b11111;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC_X = 2'b01,
        CALC_Y = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] head_x_q, head_x_d;
    logic [4:0] head_y_q, head_y_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [1:0] next_dir_q, next_dir_d;
    logic       pending_q, pending_d;
    logic       collide_q, collide_d;
    logic       overrun_q, overrun_d;

    // Picks the adder op for one axis; a blocked edge crossing degrades to hold.
    function automatic logic [4:0] axis_op(input logic inc, input logic dec, input logic blocked);
        if (blocked)  return OP_HOLD;
        else if (inc) return OP_INC;
        else if (dec) return OP_DEC;
        else          return OP_HOLD;
    endfunction

    logic x_inc, x_dec, y_inc, y_dec;
    logic x_edge, y_edge;

    always_comb begin
        x_inc  = (cur_dir_q == DIR_RIGHT);
        x_dec  = (cur_dir_q == DIR_LEFT);
        y_inc  = (cur_dir_q == DIR_DOWN);
        y_dec  = (cur_dir_q == DIR_UP);
        x_edge = !WRAP && ((x_inc && head_x_q == 5'd31) || (x_dec && head_x_q == 5'd0));
        y_edge = !WRAP && ((y_inc && head_y_q == 5'd31) || (y_dec && head_y_q == 5'd0));
    end

    always_comb begin
        state_d    = state_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        pending_d  = pending_q;
        collide_d  = collide_q;
        overrun_d  = overrun_q;
        add_a      = 5'd0;
        add_b      = 5'd0;

        if (dir_valid && (dir_in != (cur_dir_q ^ 2'b10))) begin
            next_dir_d = dir_in;
        end

        // A tick arriving mid-step is queued once; a second one is lost.
        if (state_q != IDLE && tick && !collide_q) begin
            if (!pending_q) pending_d = 1'b1;
            else            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if ((tick || pending_q) && !collide_q) begin
                    state_d   = CALC_X;
                    pending_d = 1'b0;
                    cur_dir_d = next_dir_q;
                end
            end
            CALC_X: begin
                add_a    = head_x_q;
                add_b    = axis_op(x_inc, x_dec, x_edge);
                head_x_d = add_s;
                if (x_edge) collide_d = 1'b1;
                state_d  = CALC_Y;
            end
            CALC_Y: begin
                add_a    = head_y_q;
                add_b    = axis_op(y_inc, y_dec, y_edge);
                head_y_d = add_s;
                if (y_edge) collide_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (pending_q && !collide_q) begin
                    state_d   = CALC_X;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d    = IDLE;
            head_x_d   = START_X;
            head_y_d   = START_Y;
            cur_dir_d  = START_DIR;
            next_dir_d = START_DIR;
            pending_d  = 1'b0;
            collide_d  = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            head_x_q   <= START_X;
            head_y_q   <= START_Y;
            cur_dir_q  <= START_DIR;
            next_dir_q <= START_DIR;
            pending_q  <= 1'b0;
            collide_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            pending_q  <= pending_d;
            collide_q  <= collide_d;
            overrun_q  <= overrun_d;
        end
    end

    assign head_x  = head_x_q;
    assign head_y  = head_y_q;
    assign cur_dir = cur_dir_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign collide = collide_q;
    assign overrun = overrun_q;

endmodule
